// File: rtl/ccd_linear_timing_gen_if.sv
// Control/pin bundle of the linear-CCD timing generator.
// master = acquisition-control side, slave = the timing generator itself.
interface ccd_linear_timing_gen_if #(
  parameter int INT_W = 16,
  parameter int PIX_W = 12
);
  logic             start;
  logic             cont_mode;
  logic             abort;
  logic [INT_W-1:0] int_time;
  logic             ccd_clk;
  logic             ccd_rog;
  logic             adc_start;
  logic [PIX_W-1:0] pix_idx;
  logic             frame_start;
  logic             frame_done;
  logic             int_overrun;
  logic             busy;

  modport master (
    output start, cont_mode, abort, int_time,
    input  ccd_clk, ccd_rog, adc_start, pix_idx, frame_start, frame_done, int_overrun, busy
  );

  modport slave (
    input  start, cont_mode, abort, int_time,
    output ccd_clk, ccd_rog, adc_start, pix_idx, frame_start, frame_done, int_overrun, busy
  );
endinterface

// File: rtl/ccd_linear_timing_gen.sv
// ILX511B-style linear CCD timing generator: ROG gating, ccd_clk readout, ADC strobe,
// integration timer with overlapped integration in continuous mode.
module ccd_linear_timing_gen #(
  parameter int PIXELS    = 2087,
  parameter int CLK_DIV   = 50,
  parameter int ROG_LOW   = 150,
  parameter int ROG_SETUP = 150,
  parameter int TICK_DIV  = 50000,
  parameter int INT_W     = 16,
  parameter int ADC_OFS   = 20
) (
  input logic                   sys_clk,
  input logic                   sys_rst,
  ccd_linear_timing_gen_if.slave bus
);
  localparam int PIX_W   = $clog2(PIXELS);
  localparam int PER     = 2 * CLK_DIV;
  localparam int CNT_MAX = (PER > ROG_LOW) ? ((PER > ROG_SETUP) ? PER : ROG_SETUP)
                                           : ((ROG_LOW > ROG_SETUP) ? ROG_LOW : ROG_SETUP);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] RS_LAST   = CNT_W'(ROG_SETUP - 1);
  localparam logic [CNT_W-1:0] RL_LAST   = CNT_W'(ROG_LOW - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PER - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ADC_AT    = CNT_W'(ADC_OFS);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIXELS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ROG, HOLD, INTEG, READOUT, WAIT_INT} state_t;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt, cnt_inc;
  logic               xfer, nxt_xfer;
  logic               abort_pend, nxt_pend, abort_now;
  logic [INT_W-1:0]   int_lat, int_eff, tcnt;
  logic [PRE_W-1:0]   pre;
  logic               expired, exp_evt, exp_now;
  logic               restart, lat_en, done_evt, rd_end;
  logic [PIX_W-1:0]   nxt_pix, pix_inc;

  // Timer fires in the last cycle of int_time*TICK_DIV, so the FSM can leave on that edge.
  assign int_eff = (int_lat == '0) ? INT_W'(1) : int_lat;
  assign exp_evt = !expired && (pre == PRE_LAST) && (tcnt == int_eff - INT_W'(1));
  assign exp_now = expired || exp_evt;

  assign cnt_inc   = cnt + 1'b1;
  assign abort_now = bus.abort || abort_pend;
  // pix_idx already advanced at the last rise and wrapped to 0, so 0 here marks the last pixel.
  assign rd_end    = (cnt == PER_LAST) && (bus.pix_idx == '0);
  assign pix_inc   = (bus.pix_idx == PIX_LAST) ? '0 : bus.pix_idx + 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      xfer       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      xfer       <= nxt_xfer;
      abort_pend <= nxt_pend;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = '0;
    nxt_xfer  = xfer;
    nxt_pend  = abort_pend;
    restart   = 1'b0;
    done_evt  = 1'b0;
    unique case (state)
      IDLE: begin
        nxt_pend = 1'b0;
        if (bus.start) begin
          nxt_state = SETUP;
          nxt_xfer  = 1'b0;
        end
      end
      SETUP: begin
        if (bus.abort)             nxt_state = IDLE;
        else if (cnt == RS_LAST)   nxt_state = ROG;
        else                       nxt_cnt   = cnt_inc;
      end
      ROG: begin
        // Abort is held off until the gate pulse has its full width.
        if (cnt == RL_LAST) begin
          nxt_pend = 1'b0;
          if (abort_now) nxt_state = IDLE;
          else begin
            nxt_state = HOLD;
            restart   = 1'b1;
          end
        end else begin
          nxt_cnt = cnt_inc;
          if (bus.abort) nxt_pend = 1'b1;
        end
      end
      HOLD: begin
        if (bus.abort)           nxt_state = IDLE;
        else if (cnt == RS_LAST) nxt_state = xfer ? READOUT : INTEG;
        else                     nxt_cnt   = cnt_inc;
      end
      INTEG: begin
        if (bus.abort) nxt_state = IDLE;
        else if (exp_now) begin
          nxt_state = SETUP;
          nxt_xfer  = 1'b1;
        end
      end
      READOUT: begin
        if (bus.abort) nxt_state = IDLE;
        else if (cnt == PER_LAST) begin
          if (rd_end) begin
            done_evt = 1'b1;
            if (!bus.cont_mode) nxt_state = IDLE;
            else                nxt_state = exp_now ? SETUP : WAIT_INT;
          end
        end else nxt_cnt = cnt_inc;
      end
      WAIT_INT: begin
        if (bus.abort)    nxt_state = IDLE;
        else if (exp_now) nxt_state = SETUP;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign lat_en = ((state == IDLE) && bus.start) || (restart && xfer);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      int_lat <= '0;
      pre     <= '0;
      tcnt    <= '0;
      expired <= 1'b0;
    end else begin
      if (lat_en) int_lat <= bus.int_time;
      if (restart) begin
        pre     <= '0;
        tcnt    <= '0;
        expired <= 1'b0;
      end else if (!expired) begin
        if (pre == PRE_LAST) begin
          pre  <= '0;
          tcnt <= tcnt + 1'b1;
          if (exp_evt) expired <= 1'b1;
        end else pre <= pre + 1'b1;
      end
    end
  end

  always_comb begin
    nxt_pix = '0;
    if (nxt_state == READOUT)
      nxt_pix = (state == READOUT && cnt == HALF_LAST) ? pix_inc : bus.pix_idx;
  end

  // Pins are decoded from the next state so every output is a flop.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bus.ccd_clk     <= 1'b1;
      bus.ccd_rog     <= 1'b1;
      bus.adc_start   <= 1'b0;
      bus.pix_idx     <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.int_overrun <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.ccd_clk     <= !((nxt_state == READOUT) && (nxt_cnt < HALF));
      bus.ccd_rog     <= (nxt_state != ROG);
      bus.adc_start   <= (nxt_state == READOUT) && (nxt_cnt == ADC_AT);
      bus.pix_idx     <= nxt_pix;
      bus.frame_start <= (nxt_state == READOUT) && (state != READOUT);
      bus.frame_done  <= done_evt;
      bus.int_overrun <= (state == READOUT) && exp_evt;
      bus.busy        <= (nxt_state != IDLE);
    end
  end
endmodule

// File: tb/tb_ccd_linear_timing_gen.sv
// Directed bench for ccd_linear_timing_gen with small parameters (8 pixels, CLK_DIV 4).
module tb_ccd_linear_timing_gen;
  localparam int PIXELS = 8, CLK_DIV = 4, ROG_LOW = 6, ROG_SETUP = 3;
  localparam int TICK_DIV = 10, INT_W = 16, ADC_OFS = 1;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  ccd_linear_timing_gen_if #(.INT_W(INT_W), .PIX_W(3)) bus();

  ccd_linear_timing_gen #(
    .PIXELS(PIXELS), .CLK_DIV(CLK_DIV), .ROG_LOW(ROG_LOW), .ROG_SETUP(ROG_SETUP),
    .TICK_DIV(TICK_DIV), .INT_W(INT_W), .ADC_OFS(ADC_OFS)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  int n_vec = 0, n_err = 0;

  // Event log, sampled on the falling edge; each entry is the sample index.
  int cyc = 0;
  int rf_q[$], rr_q[$], cf_q[$], cr_q[$], adc_q[$], fs_q[$], fd_q[$], ov_q[$], br_q[$], bf_q[$];
  int mon_bad = 0, last_fall = 0, aif = 0;
  logic p_clk = 1'b1, p_rog = 1'b1, p_busy = 1'b0;

  always @(negedge sys_clk) begin
    cyc    <= cyc + 1;
    p_clk  <= bus.ccd_clk;
    p_rog  <= bus.ccd_rog;
    p_busy <= bus.busy;
    if (p_rog && !bus.ccd_rog) rf_q.push_back(cyc);
    if (!p_rog && bus.ccd_rog) rr_q.push_back(cyc);
    if (p_clk && !bus.ccd_clk) begin
      cf_q.push_back(cyc);
      last_fall <= cyc;
    end
    if (!p_clk && bus.ccd_clk) cr_q.push_back(cyc);
    if (!p_busy && bus.busy) br_q.push_back(cyc);
    if (p_busy && !bus.busy) bf_q.push_back(cyc);
    if (bus.frame_done)  fd_q.push_back(cyc);
    if (bus.int_overrun) ov_q.push_back(cyc);
    if (bus.frame_start) begin
      fs_q.push_back(cyc);
      aif <= 0;
    end
    if (bus.adc_start) begin
      adc_q.push_back(cyc);
      aif <= aif + 1;
      if ((cyc - last_fall) != ADC_OFS || int'(bus.pix_idx) != aif) mon_bad <= mon_bad + 1;
    end
    if (!bus.ccd_clk && !bus.ccd_rog) mon_bad <= mon_bad + 1;
  end

  int b_rf, b_rr, b_cf, b_cr, b_adc, b_fs, b_fd, b_ov, b_br, b_bf, b_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rf = rf_q.size(); b_rr = rr_q.size(); b_cf = cf_q.size(); b_cr = cr_q.size();
    b_adc = adc_q.size(); b_fs = fs_q.size(); b_fd = fd_q.size(); b_ov = ov_q.size();
    b_br = br_q.size(); b_bf = bf_q.size(); b_bad = mon_bad;
  endtask

  task automatic start_shot(input int it, input logic cm);
    @(negedge sys_clk);
    bus.int_time  = INT_W'(it);
    bus.cont_mode = cm;
    bus.start     = 1'b1;
    @(negedge sys_clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge sys_clk);
      if (!bus.busy) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic wait_rog_low(input string tag);
    int ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (!bus.ccd_rog) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_fs(input string tag);
    int ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (bus.frame_start) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  function automatic int outs();
    return int'({bus.ccd_clk, bus.ccd_rog, bus.adc_start, bus.frame_start,
                 bus.frame_done, bus.int_overrun, bus.busy});
  endfunction

  // Continuous run: three frames, then drop cont_mode so the fourth ends it.
  task automatic cont_run(input string tag, input int it, input int gap, input int novr);
    int nfd = 0, ok = 0;
    snap();
    start_shot(it, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (bus.frame_done) nfd++;
      if (nfd == 3) begin ok = 1; break; end
    end
    chk({tag, "_3frames"}, ok, 1);
    bus.cont_mode = 1'b0;
    wait_idle({tag, "_idle"}, 600);
    chk({tag, "_frames"}, fd_q.size() - b_fd, 4);
    chk({tag, "_rogs"}, rf_q.size() - b_rf, 5);
    for (int k = 1; k <= 3; k++)
      chk($sformatf("%s_gap%0d", tag, k), rf_q[b_rf+k+1] - rr_q[b_rr+k], gap);
    chk({tag, "_overrun"}, ov_q.size() - b_ov, novr);
    chk({tag, "_adc"}, adc_q.size() - b_adc, 32);
    chk({tag, "_mon"}, mon_bad - b_bad, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.cont_mode = 1'b0; bus.abort = 1'b0; bus.int_time = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_outs", outs(), 7'b1100000);
    chk("rst_pix", int'(bus.pix_idx), 0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Single shot, int_time=2
    snap();
    start_shot(2, 1'b0);
    chk("t1_busy", int'(bus.busy), 1);
    wait_idle("t1_idle", 400);
    chk("t1_rog_cnt",   rf_q.size() - b_rf, 2);
    chk("t1_setup",     rf_q[b_rf] - br_q[b_br], 3);
    chk("t1_rog0_w",    rr_q[b_rr] - rf_q[b_rf], 6);
    chk("t1_rog1_w",    rr_q[b_rr+1] - rf_q[b_rf+1], 6);
    chk("t1_integ",     rf_q[b_rf+1] - rr_q[b_rr], 23);
    chk("t1_clk_falls", cf_q.size() - b_cf, 8);
    chk("t1_clk_rises", cr_q.size() - b_cr, 8);
    chk("t1_1st_fall",  cf_q[b_cf] - rr_q[b_rr+1], 3);
    chk("t1_low_half",  cr_q[b_cr] - cf_q[b_cf], 4);
    chk("t1_span",      cf_q[b_cf+7] - cf_q[b_cf], 56);
    chk("t1_adc",       adc_q.size() - b_adc, 8);
    chk("t1_fs_fall",   fs_q[b_fs] - cf_q[b_cf], 0);
    chk("t1_fd_cnt",    fd_q.size() - b_fd, 1);
    chk("t1_rd_len",    fd_q[b_fd] - fs_q[b_fs], 64);
    chk("t1_busy_drop", bf_q[b_bf] - fd_q[b_fd], 0);
    chk("t1_mon",       mon_bad - b_bad, 0);

    // Continuous: long integration dominates, then short integration overruns
    cont_run("t2", 10, 103, 0);
    cont_run("t3", 1, 70, 4);

    // Abort during the second ROG cycle
    snap();
    start_shot(2, 1'b0);
    wait_rog_low("t4_rog");
    @(negedge sys_clk);
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.abort = 1'b0;
    repeat (30) @(negedge sys_clk);
    chk("t4_rog_cnt", rf_q.size() - b_rf, 1);
    chk("t4_rog_w",   rr_q[b_rr] - rf_q[b_rf], 6);
    chk("t4_idle_at", bf_q[b_bf] - rr_q[b_rr], 0);
    chk("t4_no_clk",  cf_q.size() - b_cf, 0);
    chk("t4_no_fd",   fd_q.size() - b_fd, 0);
    chk("t4_busy",    int'(bus.busy), 0);

    // Abort mid-readout
    snap();
    start_shot(1, 1'b0);
    wait_fs("t5_fs");
    repeat (10) @(negedge sys_clk);
    chk("t5_pre_clk", int'(bus.ccd_clk), 0);
    chk("t5_pre_pix", int'(bus.pix_idx), 1);
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.abort = 1'b0;
    chk("t5_outs", outs(), 7'b1100000);
    chk("t5_pix",  int'(bus.pix_idx), 0);
    repeat (100) @(negedge sys_clk);
    chk("t5_no_fd", fd_q.size() - b_fd, 0);

    // Asynchronous reset mid-ROG
    start_shot(1, 1'b0);
    wait_rog_low("t6_rog");
    repeat (2) @(negedge sys_clk);
    #1 sys_rst = 1'b1;
    #1 chk("t6_outs", outs(), 7'b1100000);
    chk("t6_pix", int'(bus.pix_idx), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Asynchronous reset mid-readout
    start_shot(1, 1'b0);
    wait_fs("t7_fs");
    repeat (11) @(negedge sys_clk);
    chk("t7_pre_pix", int'(bus.pix_idx), 1);
    #1 sys_rst = 1'b1;
    #1 chk("t7_outs", outs(), 7'b1100000);
    chk("t7_pix", int'(bus.pix_idx), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // int_time=0 acts as 1; start while busy is ignored
    snap();
    start_shot(0, 1'b0);
    repeat (15) @(negedge sys_clk);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    wait_idle("t8_idle", 400);
    repeat (20) @(negedge sys_clk);
    chk("t8_integ",  rf_q[b_rf+1] - rr_q[b_rr], 13);
    chk("t8_rogs",   rf_q.size() - b_rf, 2);
    chk("t8_frames", fd_q.size() - b_fd, 1);
    chk("t8_busy",   int'(bus.busy), 0);
    chk("all_mon",   mon_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ccd_linear_timing_gen.md
# ccd_linear_timing_gen

Parametrised timing generator for linear CCD sensors of the ILX511B family, driving sensor clock (ccd_clk) and readout gate (ccd_rog) and strobing the ADC per pixel. Supports single-shot and continuous acquisition; in continuous mode integration of frame n+1 overlaps readout of frame n. Sits between the acquisition-control registers and the CCD/ADC pins; the ADC capture block consumes adc_start, frame_start and frame_done.

## Interface
- PIXELS, 2087: ccd_clk periods per readout (≥2).
- CLK_DIV, 50: sys_clk cycles per ccd_clk half-period (≥2).
- ROG_LOW, 150: sys_clk cycles ccd_rog held low (≥1).
- ROG_SETUP, 150: sys_clk cycles ccd_rog held high before each fall and after each rise (≥1).
- TICK_DIV, 50000: sys_clk cycles per integration tick (1 ms at 50 MHz).
- INT_W, 16: width of int_time.
- ADC_OFS, 20: cycles into each ccd_clk low half at which adc_start pulses (0 ≤ ADC_OFS < CLK_DIV).
- sys_clk  in  1  clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  level; sampled in IDLE only, starts acquisition.
- cont_mode  in  1  1 = continuous; sampled at end of each readout.
- abort  in  1  single-cycle request to stop.
- int_time  in  INT_W  integration ticks; 0 treated as 1.
- ccd_clk  out  1  sensor clock, idles high.
- ccd_rog  out  1  readout gate, active low, idles high.
- adc_start  out  1  1-cycle ADC conversion strobe.
- pix_idx  out  clog2(PIXELS)  current pixel, 0..PIXELS-1.
- frame_start  out  1  1-cycle pulse at first ccd_clk fall of a readout.
- frame_done  out  1  1-cycle pulse after last ccd_clk rise of a readout.
- int_overrun  out  1  1-cycle pulse when integration expires before readout ends.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- All outputs registered. Reset values: ccd_clk=1, ccd_rog=1, adc_start=0, pix_idx=0, frame_start=0, frame_done=0, int_overrun=0, busy=0; FSM=IDLE, all counters 0.
- FSM states: IDLE, SETUP, ROG, HOLD, INTEG, READOUT, WAIT_INT. Internal bit `xfer` marks flush (0) or transfer (1) ROG.
- IDLE: start=1 → SETUP, xfer=0, latch int_time.
- SETUP: ROG_SETUP cycles, ccd_rog=1 → ROG.
- ROG: ROG_LOW cycles, ccd_rog=0 → HOLD. On ROG→HOLD: integration timer restarts with latched int_time; int_time re-latched first if xfer=1.
- HOLD: ROG_SETUP cycles, ccd_rog=1 → INTEG if xfer=0, READOUT if xfer=1.
- INTEG: wait timer expiry → SETUP, xfer=1.
- READOUT: PIXELS ccd_clk periods, each CLK_DIV low then CLK_DIV high; pix_idx increments at each rising edge, wraps to 0 after last. End: cont_mode=1 → WAIT_INT; else → IDLE.
- WAIT_INT: timer expired → SETUP, xfer=1 (same cycle if already expired).
- Integration timer: tick prescaler 0..TICK_DIV-1, tick counter to int_time; expires after int_time×TICK_DIV cycles, holds expired until restarted. Expiry in READOUT → int_overrun pulse; readout completes, next ROG follows immediately.
- abort: in SETUP/HOLD/INTEG/READOUT/WAIT_INT → IDLE next cycle, ccd_clk=1, ccd_rog=1, pix_idx=0, no frame_done. In ROG: deferred until ROG_LOW completes (min ROG width never violated), then IDLE. In IDLE: ignored. abort beats start and cont_mode in the same cycle.
- start while busy ignored. cont_mode changes take effect only at readout end.

## Timing
- start sampled at edge t → busy=1 and SETUP at t+1; ccd_rog falls at t+1+ROG_SETUP.
- ccd_rog low exactly ROG_LOW cycles per pulse.
- Integration (ccd_rog rise to next ccd_rog fall), single-shot: int_time×TICK_DIV + ROG_SETUP cycles; continuous: max(int_time×TICK_DIV, ROG_SETUP + 2×CLK_DIV×PIXELS) + ROG_SETUP.
- First ccd_clk fall ROG_SETUP cycles after transfer ccd_rog rise; frame_start coincides.
- adc_start asserted ADC_OFS cycles after each ccd_clk fall; exactly PIXELS per frame.
- Readout length 2×CLK_DIV×PIXELS cycles; frame_done in the cycle after the last high half ends; busy drops same cycle in single-shot.

## Test plan
- Params PIXELS=8, CLK_DIV=4, ROG_LOW=6, ROG_SETUP=3, TICK_DIV=10, ADC_OFS=1; single-shot int_time=2 → two ROG pulses of 6 cycles, 23 cycles between 1st rise and 2nd fall, 8 ccd_clk periods of 8 cycles, 8 adc_start each 1 cycle after a fall, 1 frame_done, busy returns 0.
- Continuous int_time=10 (100 > 3+64) → 3 consecutive frames, rise-to-fall spacing 103 cycles, int_overrun never pulses.
- Continuous int_time=1 (10 < 67) → int_overrun once per frame, rise-to-fall spacing 70 cycles, no ccd_clk/ROG overlap.
- abort at 2nd ROG cycle → ccd_rog stays low all 6 cycles, then IDLE, no ccd_clk edges, no frame_done; abort mid-READOUT → ccd_clk=1, pix_idx=0 next cycle.
- Assert sys_rst asynchronously mid-ROG and mid-READOUT → all outputs at reset values without a clock edge; start during busy and int_time=0 (behaves as 1) checked.
